// File: rtl/id_stage.sv
// ARM-subset instruction decode stage.
// Holds the R0..R14 register file, evaluates the condition field against the
// status flags, decodes the control word and drives the ID/EX register.
// src1/src2/two_src are combinational for the hazard unit; everything else
// is registered with one cycle of latency.
// Pipeline semantics: there is no valid/ready handshake. ID/EX loads every
// cycle; flush squashes the whole register, and hazard turns the loaded
// entry into a bubble by zeroing its control fields only.
module id_stage #(
  parameter int NREGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction,
  input  logic        hazard,
  input  logic        flush,
  input  logic [3:0]  sr,
  input  logic        wb_en_in,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        two_src,
  output logic [31:0] pc_out,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        b,
  output logic        s,
  output logic [3:0]  exe_cmd,
  output logic [31:0] val_rn,
  output logic [31:0] val_rm,
  output logic        imm,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm_24,
  output logic [3:0]  dest
);

  logic [31:0] r_regs [0:NREGS-1];

  logic [3:0]  w_cond;
  logic [1:0]  w_mode;
  logic [3:0]  w_opcode;
  logic        w_s_bit;
  logic        w_is_str;
  logic        w_n, w_z, w_c, w_v;
  logic        w_cond_ok;
  logic        w_ctrl_en;
  logic        w_wb, w_mr, w_mw, w_b, w_s;
  logic [3:0]  w_exe;
  logic [31:0] w_val_rn, w_val_rm;

  assign w_cond   = instruction[31:28];
  assign w_mode   = instruction[27:26];
  assign w_opcode = instruction[24:21];
  assign w_s_bit  = instruction[20];
  assign w_is_str = (w_mode == 2'b01) && !w_s_bit;
  assign {w_n, w_z, w_c, w_v} = sr;

  // Operand indices seen by the hazard unit; a store reads Rd as its data operand.
  assign src1    = instruction[19:16];
  assign src2    = w_is_str ? instruction[15:12] : instruction[3:0];
  assign two_src = ~instruction[25] | w_is_str;

  // Condition field evaluated against {N,Z,C,V}; 1111 never executes.
  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ok = w_z;
      4'b0001: w_cond_ok = !w_z;
      4'b0010: w_cond_ok = w_c;
      4'b0011: w_cond_ok = !w_c;
      4'b0100: w_cond_ok = w_n;
      4'b0101: w_cond_ok = !w_n;
      4'b0110: w_cond_ok = w_v;
      4'b0111: w_cond_ok = !w_v;
      4'b1000: w_cond_ok = w_c && !w_z;
      4'b1001: w_cond_ok = !w_c || w_z;
      4'b1010: w_cond_ok = (w_n == w_v);
      4'b1011: w_cond_ok = (w_n != w_v);
      4'b1100: w_cond_ok = !w_z && (w_n == w_v);
      4'b1101: w_cond_ok = w_z || (w_n != w_v);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // Control unit: mode/opcode to ALU command and pipeline enables.
  always_comb begin
    w_wb  = 1'b0;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_b   = 1'b0;
    w_s   = 1'b0;
    w_exe = 4'b0000;
    case (w_mode)
      2'b00: begin
        w_wb = 1'b1;
        w_s  = w_s_bit;
        case (w_opcode)
          4'b1101: w_exe = 4'b0001;
          4'b1111: w_exe = 4'b1001;
          4'b0100: w_exe = 4'b0010;
          4'b0101: w_exe = 4'b0011;
          4'b0010: w_exe = 4'b0100;
          4'b0110: w_exe = 4'b0101;
          4'b0000: w_exe = 4'b0110;
          4'b1100: w_exe = 4'b0111;
          4'b0001: w_exe = 4'b1000;
          4'b1010: begin w_exe = 4'b0100; w_wb = 1'b0; end
          4'b1000: begin w_exe = 4'b0110; w_wb = 1'b0; end
          default: begin w_wb = 1'b0; w_s = 1'b0; end
        endcase
      end
      2'b01: begin
        w_exe = 4'b0010;
        w_mr  = w_s_bit;
        w_wb  = w_s_bit;
        w_mw  = !w_s_bit;
      end
      2'b10: w_b = 1'b1;
      default: ;
    endcase
  end

  assign w_ctrl_en = w_cond_ok && !hazard;

  // Register-file reads: index 15 reads 0, a same-cycle write is bypassed.
  always_comb begin
    w_val_rn = '0;
    w_val_rm = '0;
    if (int'(src1) < NREGS) begin
      if (wb_en_in && (wb_dest == src1)) w_val_rn = wb_value;
      else                               w_val_rn = r_regs[src1];
    end
    if (int'(src2) < NREGS) begin
      if (wb_en_in && (wb_dest == src2)) w_val_rm = wb_value;
      else                               w_val_rm = r_regs[src2];
    end
  end

  // Register-file write port; writes aimed at R15 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en_in && (int'(wb_dest) < NREGS)) begin
      r_regs[wb_dest] <= wb_value;
    end
  end

  // ID/EX register: flush squashes everything, hazard/cond-fail zero control only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      pc_out        <= '0;
      wb_en         <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      exe_cmd       <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      imm           <= 1'b0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      dest          <= '0;
    end else begin
      pc_out        <= pc_in;
      wb_en         <= w_ctrl_en & w_wb;
      mem_r_en      <= w_ctrl_en & w_mr;
      mem_w_en      <= w_ctrl_en & w_mw;
      b             <= w_ctrl_en & w_b;
      s             <= w_ctrl_en & w_s;
      exe_cmd       <= w_ctrl_en ? w_exe : 4'b0000;
      val_rn        <= w_val_rn;
      val_rm        <= w_val_rm;
      imm           <= instruction[25];
      shift_operand <= instruction[11:0];
      signed_imm_24 <= instruction[23:0];
      dest          <= instruction[15:12];
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: reference model + expected queue + monitor.
module tb_id_stage;

  localparam int VW = 146;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic [31:0] instruction = '0;
  logic        hazard = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  sr = '0;
  logic        wb_en_in = 1'b0;
  logic [3:0]  wb_dest = '0;
  logic [31:0] wb_value = '0;
  logic [3:0]  src1, src2;
  logic        two_src;
  logic [31:0] pc_out;
  logic        wb_en, mem_r_en, mem_w_en, b, s;
  logic [3:0]  exe_cmd;
  logic [31:0] val_rn, val_rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;

  int n_checks = 0;
  int n_errors = 0;

  logic [VW-1:0] exp_q[$];
  logic [31:0]   m_regs [0:14];

  id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction(instruction),
    .hazard(hazard), .flush(flush), .sr(sr), .wb_en_in(wb_en_in),
    .wb_dest(wb_dest), .wb_value(wb_value), .src1(src1), .src2(src2),
    .two_src(two_src), .pc_out(pc_out), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .b(b), .s(s), .exe_cmd(exe_cmd), .val_rn(val_rn),
    .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .dest(dest)
  );

  // Clock
  always #5 clk = ~clk;

  wire [VW-1:0] act_vec = {pc_out, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd,
                           val_rn, val_rm, imm, shift_operand, signed_imm_24, dest};

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Architectural condition semantics, flags taken as {N,Z,C,V}.
  function automatic bit cond_passes(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      0: return z;                1: return !z;
      2: return cf;               3: return !cf;
      4: return n;                5: return !n;
      6: return v;                7: return !v;
      8: return cf && !z;         9: return !cf || z;
      10: return n == v;          11: return n != v;
      12: return !z && (n == v);  13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] idx, input bit we,
                                         input logic [3:0] wd, input logic [31:0] wv);
    if (idx == 4'd15) return 32'd0;
    if (we && wd == idx) return wv;
    return m_regs[idx];
  endfunction

  // Expected ID/EX contents for one set of inputs.
  function automatic logic [VW-1:0] model(input logic [31:0] ins, input logic [31:0] pc,
      input logic [3:0] f, input bit hz, input bit fl, input bit we,
      input logic [3:0] wd, input logic [31:0] wv);
    bit ewb, emr, emw, eb, es;
    logic [3:0] eexe, rm_idx;
    bit store;
    ewb = 0; emr = 0; emw = 0; eb = 0; es = 0; eexe = 0;
    store = (ins[27:26] == 2'b01) && !ins[20];
    rm_idx = store ? ins[15:12] : ins[3:0];
    if (fl) return '0;
    if (ins[27:26] == 2'b00) begin
      es = ins[20];
      ewb = 1;
      case (ins[24:21])
        4'hD: eexe = 1;   4'hF: eexe = 9;
        4'h4: eexe = 2;   4'h5: eexe = 3;
        4'h2: eexe = 4;   4'h6: eexe = 5;
        4'h0: eexe = 6;   4'hC: eexe = 7;
        4'h1: eexe = 8;
        4'hA: begin eexe = 4; ewb = 0; end
        4'h8: begin eexe = 6; ewb = 0; end
        default: begin ewb = 0; es = 0; end
      endcase
    end else if (ins[27:26] == 2'b01) begin
      eexe = 2;
      if (ins[20]) begin emr = 1; ewb = 1; end
      else emw = 1;
    end else if (ins[27:26] == 2'b10) begin
      eb = 1;
    end
    if (!cond_passes(ins[31:28], f) || hz) begin
      ewb = 0; emr = 0; emw = 0; eb = 0; es = 0; eexe = 0;
    end
    return {pc, ewb, emr, emw, eb, es, eexe,
            m_read(ins[19:16], we, wd, wv), m_read(rm_idx, we, wd, wv),
            ins[25], ins[11:0], ins[23:0], ins[15:12]};
  endfunction

  // Driver: apply one cycle of inputs, check hazard-unit outputs, queue expectation.
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] f,
                       input bit hz, input bit fl, input bit we,
                       input logic [3:0] wd, input logic [31:0] wv);
    logic [3:0] e_src2;
    @(negedge clk);
    instruction = ins; pc_in = pc; sr = f; hazard = hz; flush = fl;
    wb_en_in = we; wb_dest = wd; wb_value = wv;
    exp_q.push_back(model(ins, pc, f, hz, fl, we, wd, wv));
    if (we && wd != 4'd15) m_regs[wd] = wv;
    e_src2 = ((ins[27:26] == 2'b01) && !ins[20]) ? ins[15:12] : ins[3:0];
    #1;
    check32("src1", {28'd0, src1}, {28'd0, ins[19:16]});
    check32("src2", {28'd0, src2}, {28'd0, e_src2});
    check32("two_src", {31'd0, two_src},
            {31'd0, (!ins[25]) || ((ins[27:26] == 2'b01) && !ins[20])});
  endtask

  // Monitor: ID/EX is presented every cycle, one expectation per edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [VW-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (act_vec !== e) begin
        n_errors++;
        $display("FAIL id_ex: got %h expected %h", act_vec, e);
      end
    end
  end

  // Async reset between edges; the following edge is a flush cycle.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check32("reset_outputs_lo", act_vec[31:0], 32'd0);
    check32("reset_outputs_hi", {18'd0, act_vec[VW-1:VW-14]} | act_vec[VW-15:VW-46], 32'd0);
    check32("reset_outputs_mid", act_vec[113:82] | act_vec[81:50] | act_vec[49:18], 32'd0);
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    flush = 1'b1; wb_en_in = 1'b0;
    exp_q.push_back('0);
    #1 rst = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    #2;
    check32("reset_state", {act_vec[VW-1:VW-32]} | act_vec[31:0], 32'd0);
    #6 rst = 1'b0;

    // Fill registers with known values.
    for (int i = 0; i < 15; i++)
      drive(32'hF000_0000, 32'h100 + i, 4'h0, 0, 0, 1, 4'(i), 32'hA500_0000 + i);

    // Write R2 then ADDS R3,R2,R2.
    drive(32'hF000_0000, 32'h200, 4'h0, 0, 0, 1, 4'd2, 32'hC000_0000);
    drive(32'hE092_3002, 32'h204, 4'h0, 0, 0, 0, 4'd0, 32'd0);
    after_edge();
    check32("adds_exe", {28'd0, exe_cmd}, 32'h2);
    check32("adds_s_wb", {30'd0, s, wb_en}, 32'h3);
    check32("adds_dest", {28'd0, dest}, 32'h3);
    check32("adds_rn", val_rn, 32'hC000_0000);
    check32("adds_rm", val_rm, 32'hC000_0000);

    // ADDNE with Z set, then clear.
    drive(32'h1081_1001, 32'h208, 4'b0100, 0, 0, 0, 4'd0, 32'd0);
    after_edge();
    check32("addne_fail_ctrl", {23'd0, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}, 32'd0);
    check32("addne_fail_dest", {28'd0, dest}, 32'h1);
    drive(32'h1081_1001, 32'h20C, 4'b0000, 0, 0, 0, 4'd0, 32'd0);
    after_edge();
    check32("addne_pass", {27'd0, wb_en, exe_cmd}, {27'd0, 1'b1, 4'b0010});

    // STR R1,[R0].
    drive(32'hE480_1000, 32'h210, 4'h0, 0, 0, 0, 4'd0, 32'd0);
    check32("str_src2", {28'd0, src2}, 32'h1);
    check32("str_two_src", {31'd0, two_src}, 32'h1);
    after_edge();
    check32("str_ctrl", {26'd0, mem_w_en, wb_en, exe_cmd}, {26'd0, 2'b10, 4'b0010});

    // BLT: stalled, taken, flushed.
    drive(32'hBAFF_FFF7, 32'h214, 4'b1000, 1, 0, 0, 4'd0, 32'd0);
    after_edge();
    check32("blt_hazard_b", {31'd0, b}, 32'd0);
    check32("blt_simm", {8'd0, signed_imm_24}, 32'h00FF_FFF7);
    drive(32'hBAFF_FFF7, 32'h218, 4'b1000, 0, 0, 0, 4'd0, 32'd0);
    after_edge();
    check32("blt_taken_b", {31'd0, b}, 32'd1);
    drive(32'hBAFF_FFF7, 32'h21C, 4'b1000, 1, 1, 0, 4'd0, 32'd0);
    after_edge();
    check32("flush_lo", act_vec[31:0] | act_vec[63:32], 32'd0);
    check32("flush_hi", act_vec[95:64] | act_vec[127:96] | {14'd0, act_vec[145:128]}, 32'd0);

    // CMP R5,R6 with same-edge write of R5; then an ignored write to R15.
    drive(32'hE155_0006, 32'h220, 4'h0, 0, 0, 1, 4'd5, 32'h7B);
    after_edge();
    check32("cmp_bypass_rn", val_rn, 32'h7B);
    drive(32'hF000_0000, 32'h224, 4'h0, 0, 0, 1, 4'd15, 32'hDEAD_BEEF);
    for (int i = 0; i < 15; i++)
      drive({4'hE, 8'h08, 4'(i), 4'h0, 8'h00, 4'(i)}, 32'h300 + i, 4'h0, 0, 0, 0, 4'd0, 32'd0);

    // Random stream.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
      drive(ins, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), $urandom);
      if (k == 150) pulse_reset();
    end

    // Every register reads 0 after the reset above once rewritten values are cleared.
    pulse_reset();
    for (int i = 0; i < 15; i++) begin
      drive({4'hE, 8'h08, 4'(i), 4'h0, 8'h00, 4'(i)}, 32'h400 + i, 4'h0, 0, 0, 0, 4'd0, 32'd0);
      after_edge();
      check32("post_reset_read", val_rn | val_rm, 32'd0);
    end

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
